// File: rtl/cntr_pkg.sv
// Shared types and constants for the reloading down-count modulus divider.
package cntr_pkg;
    typedef enum logic {CNTR_IDLE, CNTR_RUN} cntr_div_state_t;
    localparam int CNTR_STOP_PERIOD = 0;
endpackage

// File: rtl/cntr_period_hold.sv
// Single-entry holding register for a queued period; ready is registered as ~full.
// Entry is captured on valid & ready and released by consume; flush empties it.
module cntr_period_hold #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             flush,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             consume,
    output logic             full,
    output logic [WIDTH-1:0] data_out,
    output logic             ready
);
    logic full_nxt;

    always_comb begin
        full_nxt = full;
        if (valid && ready)
            full_nxt = 1'b1;
        else if (consume)
            full_nxt = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (flush) begin
            full     <= 1'b0;
            ready    <= 1'b1;
            data_out <= '0;
        end else begin
            full  <= full_nxt;
            ready <= ~full_nxt;
            if (valid && ready)
                data_out <= data_in;
        end
    end
endmodule

// File: rtl/cntr_divider_reload.sv
// Loadable down-count modulus divider: counts P-1..0, pulses Tick after terminal, reloads.
// New periods queue in a one-entry hold and apply only at terminal count; CNTR_DIV_UPCOUNT_EN adds qUp.
module cntr_divider_reload
    import cntr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             sClear,
    input  logic [WIDTH-1:0] PeriodData,
    input  logic             PeriodValid,
    output logic             PeriodReady,
    output logic [WIDTH-1:0] q,
    output logic             Tick,
`ifdef CNTR_DIV_UPCOUNT_EN
    output logic [WIDTH-1:0] qUp,
`endif
    output logic             Running
);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] STOP = WIDTH'(CNTR_STOP_PERIOD);

    cntr_div_state_t  state;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] reload_per;
    logic [WIDTH-1:0] pend_data;
    logic             pend_full;
    logic             xfer;
    logic             terminal;
    logic             store;
    logic             consume;

    assign xfer     = PeriodValid & PeriodReady;
    assign terminal = (state == CNTR_RUN) & Enable & ~sClear & (q == '0);
    // Terminal-edge transfers bypass the hold; IDLE transfers load directly.
    assign store    = xfer & (state == CNTR_RUN) & ~terminal;
    assign consume  = terminal & pend_full;

    cntr_period_hold #(.WIDTH(WIDTH)) u_hold (
        .Clk      (Clk),
        .flush    (~Reset_n),
        .valid    (store),
        .data_in  (PeriodData),
        .consume  (consume),
        .full     (pend_full),
        .data_out (pend_data),
        .ready    (PeriodReady)
    );

    always_comb begin
        reload_per = period;
        if (pend_full)
            reload_per = pend_data;
        else if (xfer)
            reload_per = PeriodData;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state  <= CNTR_IDLE;
            q      <= '0;
            period <= '0;
            Tick   <= 1'b0;
        end else begin
            Tick <= 1'b0;
            case (state)
                CNTR_IDLE: begin
                    if (xfer && PeriodData != STOP) begin
                        state  <= CNTR_RUN;
                        period <= PeriodData;
                        q      <= PeriodData - ONE;
                    end
                end
                CNTR_RUN: begin
                    if (Enable) begin
                        if (sClear) begin
                            q <= period - ONE;
                        end else if (q != '0) begin
                            q <= q - ONE;
                        end else begin
                            Tick <= 1'b1;
                            if (reload_per == STOP) begin
                                state <= CNTR_IDLE;
                                q     <= '0;
                            end else begin
                                period <= reload_per;
                                q      <= reload_per - ONE;
                            end
                        end
                    end
                end
                default: state <= CNTR_IDLE;
            endcase
        end
    end

    assign Running = (state == CNTR_RUN);

`ifdef CNTR_DIV_UPCOUNT_EN
    assign qUp = (state == CNTR_RUN) ? (period - ONE - q) : '0;
`endif
endmodule

// File: tb/tb_cntr_divider_reload.sv
// Bench for cntr_divider_reload: vector table, directed corner sequences, random vs phase model.
module tb_cntr_divider_reload;
    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Enable = 1'b0;
    logic         sClear = 1'b0;
    logic         PeriodValid = 1'b0;
    logic [W-1:0] PeriodData = '0;
    logic         PeriodReady;
    logic [W-1:0] q;
    logic         Tick;
    logic         Running;
`ifdef CNTR_DIV_UPCOUNT_EN
    logic [W-1:0] qUp;
`endif

    always #5 Clk = ~Clk;

    cntr_divider_reload #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Enable      (Enable),
        .sClear      (sClear),
        .PeriodData  (PeriodData),
        .PeriodValid (PeriodValid),
        .PeriodReady (PeriodReady),
        .q           (q),
        .Tick        (Tick),
`ifdef CNTR_DIV_UPCOUNT_EN
        .qUp         (qUp),
`endif
        .Running     (Running)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         rst_n, en, clr, vld;
        logic [W-1:0] dat;
        logic [W-1:0] q;
        logic         tick, run, rdy;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic r, e, c, v, input logic [W-1:0] d,
                                input logic [W-1:0] eq, input logic et, er, ey);
        vec_t t;
        t.rst_n = r; t.en = e; t.clr = c; t.vld = v; t.dat = d;
        t.q = eq; t.tick = et; t.run = er; t.rdy = ey;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, e, c, v, input logic [W-1:0] d);
        Reset_n = r; Enable = e; sClear = c; PeriodValid = v; PeriodData = d;
        @(posedge Clk);
        #1;
        PeriodValid = 1'b0;
    endtask

    // Reference model: elapsed phase within the current period plus a pending queue.
    bit          m_run, m_tick;
    int unsigned m_per, m_phase;
    int unsigned pend[$];

    task automatic model_step(input bit r, e, c, v, input int unsigned d);
        bit          xfer;
        int unsigned np;
        xfer   = v && (pend.size() == 0);
        m_tick = 1'b0;
        if (!r) begin
            m_run = 1'b0; m_per = 0; m_phase = 0; pend.delete();
        end else if (!m_run) begin
            if (xfer && d != 0) begin
                m_run = 1'b1; m_per = d; m_phase = 0;
            end
        end else if (e && !c && m_phase == m_per - 1) begin
            m_tick = 1'b1;
            if (pend.size() != 0) np = pend.pop_front();
            else if (xfer)        np = d;
            else                  np = m_per;
            if (np == 0) m_run = 1'b0;
            else         m_per = np;
            m_phase = 0;
        end else begin
            if (xfer) pend.push_back(d);
            if (e) m_phase = c ? 0 : m_phase + 1;
        end
    endtask

    initial begin
        tbl[0]  = mk(0,0,0,0,0,  0,0,0,1);
        tbl[1]  = mk(0,0,0,0,0,  0,0,0,1);
        tbl[2]  = mk(1,1,0,1,4,  3,0,1,1);
        tbl[3]  = mk(1,1,0,0,0,  2,0,1,1);
        tbl[4]  = mk(1,1,0,0,0,  1,0,1,1);
        tbl[5]  = mk(1,1,0,0,0,  0,0,1,1);
        tbl[6]  = mk(1,1,0,0,0,  3,1,1,1);
        tbl[7]  = mk(1,1,0,0,0,  2,0,1,1);
        tbl[8]  = mk(1,1,0,1,2,  1,0,1,0);
        tbl[9]  = mk(1,1,0,0,0,  0,0,1,0);
        tbl[10] = mk(1,1,0,0,0,  1,1,1,1);
        tbl[11] = mk(1,1,0,0,0,  0,0,1,1);
        tbl[12] = mk(1,1,0,0,0,  1,1,1,1);
        tbl[13] = mk(1,1,0,0,0,  0,0,1,1);
        tbl[14] = mk(1,1,0,1,3,  2,1,1,1);
        tbl[15] = mk(1,1,0,0,0,  1,0,1,1);
        tbl[16] = mk(1,1,0,0,0,  0,0,1,1);
        tbl[17] = mk(1,1,0,1,5,  4,1,1,1);
        tbl[18] = mk(1,1,0,0,0,  3,0,1,1);

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].rst_n, tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].dat);
            chk($sformatf("vec%0d q", i),     q,                 tbl[i].q);
            chk($sformatf("vec%0d tick", i),  W'(Tick),          W'(tbl[i].tick));
            chk($sformatf("vec%0d run", i),   W'(Running),       W'(tbl[i].run));
            chk($sformatf("vec%0d ready", i), W'(PeriodReady),   W'(tbl[i].rdy));
        end

        // Stop via queued P=0: one final Tick, then idle and deaf to Enable.
        cyc(0,0,0,0,0);
        cyc(1,1,0,1,6);
        chk("stop load q", q, 5);
        cyc(1,1,0,1,0);
        chk("stop queued ready", W'(PeriodReady), 0);
        for (int i = 0; i < 4; i++) cyc(1,1,0,0,0);
        chk("stop pre-term q", q, 0);
        chk("stop pre-term tick", W'(Tick), 0);
        cyc(1,1,0,0,0);
        chk("stop tick", W'(Tick), 1);
        chk("stop running", W'(Running), 0);
        chk("stop q", q, 0);
        chk("stop ready", W'(PeriodReady), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1,1,0,0,0);
            chk("idle tick", W'(Tick), 0);
            chk("idle q", q, 0);
        end

        // Hold with Enable low, sClear restart, then reset with pending full.
        cyc(0,0,0,0,0);
        cyc(1,1,0,1,8);
        cyc(1,1,0,0,0);
        cyc(1,1,0,0,0);
        chk("hold start q", q, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(1,0,0,0,0);
            chk("hold q", q, 5);
            chk("hold tick", W'(Tick), 0);
        end
        cyc(1,1,1,0,0);
        chk("sclear q", q, 7);
        chk("sclear tick", W'(Tick), 0);
        cyc(1,0,0,1,3);
        chk("pend ready", W'(PeriodReady), 0);
        cyc(0,1,0,0,0);
        chk("rst ready", W'(PeriodReady), 1);
        chk("rst running", W'(Running), 0);
        chk("rst q", q, 0);
        cyc(1,1,0,0,0);
        cyc(1,1,0,0,0);
        chk("rst discards pend", W'(Running), 0);

        // Maximum period, then P=1 with gated Enable.
        cyc(1,1,0,1,16'hFFFF);
        chk("max period q", q, 16'hFFFE);
        cyc(0,0,0,0,0);
        cyc(1,0,0,1,1);
        chk("p1 q", q, 0);
        chk("p1 running", W'(Running), 1);
        chk("p1 first tick", W'(Tick), 0);
        cyc(1,1,0,0,0); chk("p1 tick e1", W'(Tick), 1);
        cyc(1,0,0,0,0); chk("p1 tick e0", W'(Tick), 0);
        cyc(1,1,0,0,0); chk("p1 tick e1b", W'(Tick), 1);
        cyc(1,1,0,0,0); chk("p1 tick e1c", W'(Tick), 1);
        chk("p1 q end", q, 0);

`ifdef CNTR_DIV_UPCOUNT_EN
        cyc(0,0,0,0,0);
        chk("qup idle", qUp, 0);
        cyc(1,1,0,1,4);
        chk("qup 0", qUp, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1,1,0,0,0);
            chk("qup seq", qUp, W'(i % 4));
        end
`endif

        // Randomized run against the phase model.
        model_step(0,0,0,0,0);
        cyc(0,0,0,0,0);
        for (int i = 0; i < 4000; i++) begin
            logic         r, e, c, v;
            logic [W-1:0] d;
            r = ($urandom_range(0,99) != 0);
            e = ($urandom_range(0,3) != 0);
            c = ($urandom_range(0,9) == 0);
            v = ($urandom_range(0,2) == 0);
            d = ($urandom_range(0,19) == 0) ? W'($urandom) : W'($urandom_range(0,6));
            model_step(r, e, c, v, d);
            cyc(r, e, c, v, d);
            chk("rand q", q, m_run ? W'(m_per - 1 - m_phase) : '0);
            chk("rand tick", W'(Tick), W'(m_tick));
            chk("rand running", W'(Running), W'(m_run));
            chk("rand ready", W'(PeriodReady), W'(pend.size() == 0));
`ifdef CNTR_DIV_UPCOUNT_EN
            chk("rand qup", qUp, m_run ? W'(m_phase) : '0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cntr_divider_reload.md
Name: cntr_divider_reload

Overview:
- Loadable down-counting modulus divider: the reloading counterpart to the free-running up modulus counter.
- Accepts a period P over a valid/ready handshake, counts P-1 down to 0 on each enabled cycle, pulses Tick at each terminal count, then reloads.
- A new period queued mid-run is applied only at the terminal-count boundary, so the FM sample/phase-rate strobes never produce glitched intervals.

Parameters:
- WIDTH, 16, width of period and count.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset.
- Enable  input  1  count-advance qualifier.
- sClear  input  1  restart the current period; gated by Enable, as in the up counter.
- PeriodData  input  WIDTH  new period P.
- PeriodValid  input  1  PeriodData is valid.
- PeriodReady  output  1  block can accept a period.
- q  output  WIDTH  current down-count.
- Tick  output  1  registered one-cycle terminal-count pulse.
- Running  output  1  high in state RUN.

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-low (Reset_n sampled on the rising edge of Clk).
- Reset (Reset_n=0 at edge):
  - q=0, Tick=0, Running=0, PeriodReady=1.
  - State IDLE; pending register empty; period register=0.
  - Applies mid-run too: any pending value is discarded.
- Handshake:
  - Transfer occurs when PeriodValid & PeriodReady at a rising edge.
  - PeriodReady = ~pending_full, registered. No combinational path from PeriodValid.
- States: IDLE and RUN.
- IDLE:
  - q holds 0; Enable and sClear are ignored.
  - A transfer with P≥1 moves to RUN at the next edge with q=P-1 and period=P, irrespective of Enable.
  - A transfer with P=0 is accepted and the block stays in IDLE.
- RUN, per edge, in priority order:
  1. Enable=0: q holds. Handshake still operates.
  2. Enable & sClear: q=period-1, Tick=0. Pending entry kept.
  3. Enable & q!=0: q=q-1.
  4. Enable & q==0 (terminal): Tick=1 for the following cycle, then reload:
     - If pending is full, apply pending.
     - Else if a transfer occurs this same edge, apply PeriodData directly (bypass; it does not occupy pending).
     - Else reload the same period.
     - Applying P≥1: period=P, q=P-1.
     - Applying P=0: state IDLE, q=0, Running=0. Tick for this final terminal is still asserted.
- A transfer in RUN on a non-terminal edge fills pending, so PeriodReady=0 from the next cycle. Pending empties at the terminal edge, so PeriodReady=1 the cycle after the terminal edge.
- P=1: q stays 0; Tick is high on every cycle following an enabled edge.
- Tick is never asserted in IDLE or on an sClear edge.
- Arithmetic: unsigned WIDTH bits. Maximum P = 2^WIDTH-1. Load is always P-1 and never underflows, because P=0 is handled by the stop path.

Optional Feature:
- Macro: CNTR_DIV_UPCOUNT_EN.
- Defined: adds output qUp, width WIDTH, combinationally equal to period-1-q in RUN and 0 in IDLE. This gives an up-count phase identical in sequence to the up modulus counter with MODVAL=P.
- Undefined: port qUp and its logic are absent; all other behaviour is identical.

Decomposition:
- Package cntr_pkg holds:
  - typedef enum logic {CNTR_IDLE, CNTR_RUN} cntr_div_state_t;
  - localparam CNTR_STOP_PERIOD = 0.
- One sub-module: cntr_period_hold, a single-entry holding register. Inputs: valid/data, consume, flush. Outputs: full, data, ready.
- The FSM and counter stay in cntr_divider_reload.

Test Plan:
- Reset_n=0 for 2 cycles, then load P=4 with Enable=1 → q sequence 3,2,1,0,3,…; Tick on the cycle after each q==0 edge (every 4 cycles); Running=1.
- Running P=4, send P=2 when q=2 → PeriodReady=0 next cycle; q continues 1,0; then q=1,0,1,0; PeriodReady=1 the cycle after the terminal edge.
- Running P=3, PeriodValid with P=5 asserted exactly on a q==0 Enable edge with pending empty → bypass: q=4 next cycle; pending stays empty; PeriodReady stays 1.
- Running P=6, load P=0 → at next terminal: Tick=1 once, Running=0, q=0; further Enable has no effect and no Tick.
- Running P=8 at q=5: Enable=0 for 3 cycles holds q=5; then sClear with Enable=1 gives q=7 and no Tick. Separately, Reset_n=0 with pending full gives PeriodReady=1, IDLE, q=0.
- P=1 with Enable toggled 1,0,1,1 → Tick pattern 1,0,1,1 (one cycle later); q always 0. With CNTR_DIV_UPCOUNT_EN defined and P=4: qUp=0,1,2,3 repeating.
